// File: rtl/user_clk_pkg.sv
// Shared types and defaults for the user clock-switch controller.
package user_clk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  localparam logic SEL_IN1 = 1'b0;
  localparam logic SEL_IN2 = 1'b1;

  localparam int DEF_HB_TIMEOUT    = 64;
  localparam int DEF_SETTLE_CYCLES = 16;

endpackage

// File: rtl/user_clk_hb_mon.sv
// Heartbeat monitor: synchronizes a toggle from a foreign clock domain and
// declares the source alive while toggles keep arriving within HB_TIMEOUT cycles.
module user_clk_hb_mon
  import user_clk_pkg::*;
#(
  parameter int HB_TIMEOUT = DEF_HB_TIMEOUT
) (
  input  logic i_aclk,
  input  logic i_areset,
  input  logic i_hb,
  output logic o_alive
);

  localparam int             CW      = $clog2(HB_TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(HB_TIMEOUT);

  logic [1:0]    r_sync;
  logic          r_prev;
  logic [CW-1:0] r_cnt;
  logic          r_alive;
  logic          w_toggle;

  assign w_toggle = r_sync[1] ^ r_prev;
  assign o_alive  = r_alive;

  // Counter starts saturated so a source is only trusted after a real edge.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_cnt   <= CNT_MAX;
      r_alive <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_hb};
      r_prev  <= r_sync[1];
      if (w_toggle)             r_cnt <= '0;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
      r_alive <= (r_cnt < CNT_MAX);
    end
  end

endmodule

// File: rtl/user_clk_switch_ctrl.sv
// Sequences the BUFGMUX select from the always-on control clock: liveness
// check, select change, settle wait, plus optional automatic failover.
module user_clk_switch_ctrl
  import user_clk_pkg::*;
#(
  parameter logic RESET_SEL     = SEL_IN1,
  parameter int   HB_TIMEOUT    = DEF_HB_TIMEOUT,
  parameter int   SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter bit   AUTO_FAILOVER = 1'b1
) (
  input  logic aclk,
  input  logic areset,
  input  logic hb_in1,
  input  logic hb_in2,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic selection,
  output logic active_sel,
  output logic busy,
  output logic sw_done,
  output logic sw_err,
  output logic alive1,
  output logic alive2
);

  localparam int            SW        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SCNT_LOAD = SW'(SETTLE_CYCLES - 1);

  state_e        r_state, w_next;
  logic          r_sel, r_active, r_tgt, r_done, r_err;
  logic [SW-1:0] r_scnt;

  logic w_alive_act, w_alive_oth, w_alive_tgt;
  logic w_failover, w_accept, w_start, w_done_nxt, w_err_nxt;

  user_clk_hb_mon #(.HB_TIMEOUT(HB_TIMEOUT)) u_mon1 (
    .i_aclk(aclk), .i_areset(areset), .i_hb(hb_in1), .o_alive(alive1)
  );
  user_clk_hb_mon #(.HB_TIMEOUT(HB_TIMEOUT)) u_mon2 (
    .i_aclk(aclk), .i_areset(areset), .i_hb(hb_in2), .o_alive(alive2)
  );

  assign w_alive_act = r_active ? alive2 : alive1;
  assign w_alive_oth = r_active ? alive1 : alive2;
  assign w_alive_tgt = r_tgt    ? alive2 : alive1;

  // Outputs and decode, all from registered state and liveness.
  always_comb begin
    w_failover = AUTO_FAILOVER && !w_alive_act && w_alive_oth;
    req_ready  = (r_state == ST_IDLE) && !w_failover;
    w_accept   = req_valid && req_ready;
    w_start    = (r_state == ST_IDLE) && (w_failover || (w_accept && (req_sel != r_active)));
    w_done_nxt = (w_accept && (req_sel == r_active)) ||
                 ((r_state == ST_SETTLE) && (r_scnt == '0));
    w_err_nxt  = (r_state == ST_CHECK) && !w_alive_tgt;
    busy       = (r_state != ST_IDLE);
    selection  = r_sel;
    active_sel = r_active;
    sw_done    = r_done;
    sw_err     = r_err;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_next = ST_CHECK;
      ST_CHECK:  w_next = w_alive_tgt ? ST_SETTLE : ST_IDLE;
      ST_SETTLE: if (r_scnt == '0) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= ST_IDLE;
      r_sel    <= RESET_SEL;
      r_active <= RESET_SEL;
      r_tgt    <= RESET_SEL;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_scnt   <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (r_state == ST_IDLE)
        r_tgt <= w_failover ? !r_active : req_sel;
      if ((r_state == ST_CHECK) && w_alive_tgt) begin
        r_sel  <= r_tgt;
        r_scnt <= SCNT_LOAD;
      end
      // Liveness is deliberately not sampled while settling.
      if (r_state == ST_SETTLE) begin
        if (r_scnt == '0) r_active <= r_sel;
        else              r_scnt   <= r_scnt - SW'(1);
      end
    end
  end

endmodule

// File: doc/user_clk_switch_ctrl.md
Name: user_clk_switch_ctrl

Overview:
- Sequences the select input of the global clock mux buffer (user_bufgmux) from a free-running, always-present control clock.
- Accepts switch requests over a valid/ready handshake and checks that the target clock is alive using heartbeat monitors.
- Drives `selection`, waits a settle period, then reports completion or error.
- Optionally fails over automatically when the active clock stops.

Parameters:
- RESET_SEL, 0, value of `selection`/`active_sel` out of reset (0 = aclk_in1, 1 = aclk_in2)
- HB_TIMEOUT, 64, aclk cycles without a heartbeat toggle before a source is declared dead (>=4)
- SETTLE_CYCLES, 16, aclk cycles between `selection` change and `sw_done` (>=1)
- AUTO_FAILOVER, 1, 1 = switch automatically to the other source when the active source is dead and the other is alive

Ports:
- aclk  in  1  free-running control clock (not either muxed clock)
- areset  in  1  asynchronous, active-high reset
- hb_in1  in  1  heartbeat toggle from the aclk_in1 domain (divided clock, asynchronous to aclk)
- hb_in2  in  1  heartbeat toggle from the aclk_in2 domain
- req_valid  in  1  switch request valid
- req_sel  in  1  requested source (0 = in1, 1 = in2)
- req_ready  out  1  request accepted when req_valid && req_ready
- selection  out  1  to mux S input, registered
- active_sel  out  1  source confirmed settled
- busy  out  1  switch in progress
- sw_done  out  1  one-cycle pulse: switch complete or no-op request complete
- sw_err  out  1  one-cycle pulse: target source dead, request rejected
- alive1, alive2  out  1  per-source liveness

Behaviour:
- Reset values (asynchronous, on areset high):
  - selection = active_sel = RESET_SEL
  - busy = sw_done = sw_err = 0
  - alive1 = alive2 = 0
  - heartbeat counters = HB_TIMEOUT
  - synchronizer flops = 0
  - state = IDLE
- Reset asserted mid-switch aborts immediately; `selection` returns to RESET_SEL.
- Heartbeat monitor (per source):
  - 2-FF synchronizer on hb_inN, then a third flop for edge detection.
  - Any toggle clears the counter to 0; otherwise the counter increments, saturating at HB_TIMEOUT.
  - aliveN = (counter < HB_TIMEOUT), registered.
  - Counter width is clog2(HB_TIMEOUT+1).
- FSM states: IDLE, CHECK, SETTLE.
- req_ready = (state == IDLE) && !failover_cond. It is combinational from registered state and alive flags.
- failover_cond = AUTO_FAILOVER && !alive(active_sel) && alive(!active_sel).
- Failover has priority over an external request in the same cycle. It starts an internal switch to !active_sel.
- IDLE, request accepted with req_sel == active_sel: sw_done pulses the next cycle; state stays IDLE; `selection` unchanged.
- IDLE, request accepted with a different target (or failover_cond): latch target; go to CHECK; busy = 1 from the next cycle.
- CHECK (1 cycle):
  - If alive(target): `selection` <= target, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
  - Else: sw_err pulses the next cycle, busy drops, return to IDLE; `selection` unchanged.
- SETTLE:
  - Decrement the counter each cycle.
  - When the counter is 0: active_sel <= selection, sw_done pulse, busy = 0, go to IDLE.
  - Liveness changes during SETTLE are ignored; a failover evaluates in IDLE afterwards.
- Latency, with acceptance at edge T0:
  - `selection` changes at T2.
  - sw_done and active_sel update at T2+SETTLE_CYCLES.
- Requests while busy are not accepted (req_ready = 0). The requester holds req_valid/req_sel stable until accepted.
- Both sources dead: failover_cond = 0; requests error out; `selection` holds.
- sw_done and sw_err are never high in the same cycle.

Decomposition:
- Shared package user_clk_pkg holds:
  - state enum (IDLE, CHECK, SETTLE)
  - SEL_IN1 = 0, SEL_IN2 = 1 constants
  - default HB_TIMEOUT and SETTLE_CYCLES values
- Sub-module user_clk_hb_mon (synchronizer + edge detect + timeout counter -> alive), instantiated once per source.

Test Plan:
1. Reset with RESET_SEL=0, toggle both heartbeats every 8 cycles, request req_sel=1 -> selection=1 at acceptance+2, sw_done and active_sel=1 at acceptance+18 (SETTLE_CYCLES=16), busy high in between.
2. Stop hb_in2 for >64 cycles (alive2=0), request req_sel=1 -> sw_err pulse 2 cycles after acceptance, selection stays 0, no sw_done.
3. Active=0, stop hb_in1 with hb_in2 running, AUTO_FAILOVER=1 -> alive1 falls 64-67 cycles after last toggle, req_ready drops, selection=1, then sw_done and active_sel=1; with AUTO_FAILOVER=0 -> no change.
4. Request req_sel equal to active_sel -> sw_done the next cycle, selection never toggles, busy stays 0.
5. Assert areset during SETTLE after a switch to 1 -> selection, active_sel and busy return to 0 and 0 and 0 asynchronously; alive flags 0 until a new heartbeat edge.
6. Hold req_valid during a switch and issue a request in the same cycle as failover_cond -> req_ready=0 throughout busy; failover wins; the held request is accepted in the first IDLE cycle after sw_done.
